// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry rising-edge skid register with valid/ready on both sides.
// Accepts words from falling-edge latch stages and hands them to rising-edge
// consumers. Every output comes from flops, so no ready path crosses the stage
// combinationally.
//
// Ports:
//   clock       single clock; all state changes on the rising edge
//   ctrl_reset  asynchronous reset, active low
//   flush       synchronous clear of both entries
//   in_valid    upstream word present on data_in
//   in_ready    room for a word this cycle (skid entry free)
//   data_in     upstream word
//   out_valid   data_out holds a valid word (main entry)
//   out_ready   downstream takes data_out this cycle
//   data_out    head word
//   occupancy   number of held words: 0, 1 or 2
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       occupancy
);

  // The state encoding is {main_v, skid_v}, so the valid bits fall straight
  // out of the state register.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_data, main_nxt;
  logic [WIDTH-1:0] skid_data, skid_nxt;
  logic             main_v, skid_v;
  logic             push, pop;

  assign main_v    = state[1];
  assign skid_v    = state[0];
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign data_out  = main_data;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_data;
    skid_nxt  = skid_data;
    if (flush) begin
      // A squash wins over any handshake on the same edge.
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_nxt  = data_in;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_nxt = data_in;
          end else if (pop) begin
            state_nxt = EMPTY;
          end else if (push) begin
            skid_nxt  = data_in;
            state_nxt = FULL;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            main_nxt  = skid_data;
            state_nxt = ONE;
          end
        end
        default: begin
          // {0,1} cannot be reached; fall back to empty.
          state_nxt = EMPTY;
          main_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_nxt;
      skid_data <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: walks through reset, streaming,
// backpressure, push+pop in ONE, pop from FULL, flush and a mid-cycle
// asynchronous reset. Expected values are written out by hand for each step.
module tb_pipe_skid_reg;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .occupancy (occupancy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic ov, input logic [31:0] dout,
                           input logic ir, input logic [1:0] occ);
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, ov});
    chk({tag, ".data_out"},  data_out, dout);
    chk({tag, ".in_ready"},  {31'b0, in_ready}, {31'b0, ir});
    chk({tag, ".occupancy"}, {30'b0, occupancy}, {30'b0, occ});
  endtask

  initial begin
    ctrl_reset = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    out_ready  = 1'b0;

    // Reset state
    #3;
    chk_state("reset", 1'b0, 32'h0, 1'b1, 2'd0);
    @(posedge clock);
    @(negedge clock);
    ctrl_reset = 1'b1;

    // Streaming: one word per cycle, 1-cycle latency, occupancy never above 1
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = i;
      tick();
      chk_state($sformatf("stream%0d", i), 1'b1, i, 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    chk_state("stream_drain", 1'b0, 32'h8, 1'b1, 2'd0);

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'hAAAA0001;
    tick();
    chk_state("bp_push1", 1'b1, 32'hAAAA0001, 1'b1, 2'd1);
    data_in = 32'hAAAA0002;
    tick();
    chk_state("bp_push2", 1'b1, 32'hAAAA0001, 1'b0, 2'd2);
    data_in = 32'hAAAA0003;
    tick();
    chk_state("bp_held", 1'b1, 32'hAAAA0001, 1'b0, 2'd2);
    out_ready = 1'b1;
    tick();
    chk_state("bp_rel1", 1'b1, 32'hAAAA0002, 1'b1, 2'd1);
    tick();
    chk_state("bp_rel2", 1'b1, 32'hAAAA0003, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    chk_state("bp_empty", 1'b0, 32'hAAAA0003, 1'b1, 2'd0);

    // Simultaneous push + pop in ONE
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'h11;
    tick();
    chk_state("pp_one", 1'b1, 32'h11, 1'b1, 2'd1);
    data_in   = 32'h22;
    out_ready = 1'b1;
    tick();
    chk_state("pp_swap", 1'b1, 32'h22, 1'b1, 2'd1);
    in_valid = 1'b0;
    tick();
    chk_state("pp_drain", 1'b0, 32'h22, 1'b1, 2'd0);

    // Pop from FULL with in_valid high: the incoming word must not be taken
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'h33;
    tick();
    data_in = 32'h44;
    tick();
    chk_state("full_fill", 1'b1, 32'h33, 1'b0, 2'd2);
    data_in   = 32'h55;
    out_ready = 1'b1;
    tick();
    chk_state("full_pop", 1'b1, 32'h44, 1'b1, 2'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_state("full_nocap", 1'b1, 32'h44, 1'b1, 2'd1);
    tick();
    chk("stable_hold", data_out, 32'h44);

    // Flush from FULL overrides push and pop
    in_valid = 1'b1;
    data_in  = 32'h66;
    tick();
    chk_state("fl_full", 1'b1, 32'h44, 1'b0, 2'd2);
    flush     = 1'b1;
    data_in   = 32'h77;
    out_ready = 1'b1;
    tick();
    chk_state("flush", 1'b0, 32'h0, 1'b1, 2'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_state("post_flush", 1'b0, 32'h0, 1'b1, 2'd0);

    // Asynchronous reset mid-cycle while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 32'h88;
    tick();
    data_in = 32'h99;
    tick();
    chk_state("rst_full", 1'b1, 32'h88, 1'b0, 2'd2);
    #3;
    ctrl_reset = 1'b0;
    #1;
    chk_state("rst_async", 1'b0, 32'h0, 1'b1, 2'd0);
    tick();
    chk_state("rst_hold", 1'b0, 32'h0, 1'b1, 2'd0);
    @(negedge clock);
    ctrl_reset = 1'b1;
    data_in    = 32'hAB;
    tick();
    chk_state("rst_after", 1'b1, 32'hAB, 1'b1, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
